// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter slice.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 64;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/booth_arbiter_if.sv
// Request/response channel between client blocks and the Booth arbiter.
interface booth_arbiter_if
    import booth_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = prod_width(WIDTH);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [PW-1:0]         resp_product;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, resp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_valid
);
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (en && !gnt_valid && req[j]) begin
                gnt[j]    = 1'b1;
                gnt_idx   = IDW'(j);
                gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/booth_arbiter.sv
// Shares one sequential Booth multiplier between NREQ requesters, round-robin,
// returning each signed product (or a timeout error) over a valid/ready channel.
module booth_arbiter
    import booth_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = DEFAULT_WIDTH,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int PW      = prod_width(WIDTH),
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    booth_arbiter_if.slave   bus,
    output logic             busy,
    output logic             mul_load,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [PW-1:0]    mul_product,
    input  logic             mul_done
);
    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    product_q, product_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q;
    logic             mul_load_q, mul_load_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_valid;
    logic             done_rise;

    // Grants are only offered in IDLE and never while reset is being applied.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .en        ((state_q == ST_IDLE) && rst),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // A done level held over from the previous operation is not a completion.
    assign done_rise = mul_done && !done_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    a_d      = bus.req_a[gnt_idx*WIDTH +: WIDTH];
                    b_d      = bus.req_b[gnt_idx*WIDTH +: WIDTH];
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    product_d = mul_product;
                    err_d     = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    product_d = '0;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        mul_load_d   = (state_d == ST_LOAD);
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            product_q    <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            mul_load_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            product_q    <= product_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            done_q       <= mul_done;
            mul_load_q   <= mul_load_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready    = gnt;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = id_q;
    assign bus.resp_product = product_q;
    assign bus.resp_err     = err_q;
    assign busy             = busy_q;
    assign mul_load         = mul_load_q;
    assign mul_a            = a_q;
    assign mul_b            = b_q;
endmodule
